image_block_writer: RTL and testbench
=====================================

Name: image_block_writer

Overview:
- Sequences decoded 8x8 pixel tables from the IDCT into the frame image RAM, one pixel write per clock.
- Accepts a complete table over a valid/ready handshake, captures it into an internal buffer, and tracks the block position within the frame (raster order: left to right, then top to bottom).
- Generates the raster RAM address for each pixel.
- Sits between the IDCT output and the image RAM write port, and flags block and frame completion to the top-level decoder control.

Parameters:
- IMAGE_WIDTH, 320, frame width in pixels; must be a multiple of 8.
- IMAGE_HEIGHT, 240, frame height in pixels; must be a multiple of 8.
- PIXEL_WIDTH, 8, bits per pixel.
- TABLE_SIZE, 64, pixels per block; fixed 8x8, and no other value is supported.
- ADDR_WIDTH, 17, image RAM address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- table_data  in  TABLE_SIZE*PIXEL_WIDTH  decoded block; pixel p = row*8+col is at [p*PIXEL_WIDTH +: PIXEL_WIDTH].
- table_valid  in  1  table_data holds a complete block.
- table_ready  out  1  block can be accepted this cycle.
- restart  in  1  synchronous request to return the block position to (0,0).
- image_RAM_address  out  ADDR_WIDTH  pixel write address.
- image_RAM_data  out  PIXEL_WIDTH  pixel write data.
- image_RAM_WE  out  1  write enable; one pixel is written per high cycle.
- block_done  out  1  one-cycle pulse marking the last write of a block.
- frame_done  out  1  one-cycle pulse marking the last write of a frame.
- busy  out  1  high while in WRITE.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; block column bx=0; block row by=0; pixel counter=0; all outputs 0 except table_ready=1.
- Reset during WRITE abandons the current block; no further writes are issued.
- Derived sizes: BLOCK_COLS=IMAGE_WIDTH/8 and BLOCK_ROWS=IMAGE_HEIGHT/8.
- State machine has two states, IDLE and WRITE.
- IDLE:
  - table_ready=1, image_RAM_WE=0.
  - On table_valid && table_ready at an edge: capture table_data into the internal buffer, clear the pixel counter k to 0, go to WRITE.
- WRITE:
  - table_ready=0; table_valid and table_data are ignored.
  - All outputs are registered.
  - In the k-th WRITE cycle (k=0..63): image_RAM_WE=1, image_RAM_data=buffer pixel k, image_RAM_address=(by*8 + k[5:3])*IMAGE_WIDTH + bx*8 + k[2:0].
  - After the k=63 cycle, return to IDLE.
- Latency and throughput:
  - A handshake at edge t produces writes in cycles t+1 through t+64.
  - table_ready is high again in cycle t+65.
  - Throughput is 65 cycles per block with no back-to-back acceptance.
- Address width: address arithmetic is computed at full width and truncated to ADDR_WIDTH; the result is never truncated in a legal configuration. The implementation may compute addresses incrementally (no multiplier required) but must produce identical values.
- block_done is high in the k=63 write cycle only.
- Position advance, on the edge that ends k=63:
  - If bx == BLOCK_COLS-1: bx=0, and by advances (by == BLOCK_ROWS-1 wraps to 0).
  - Otherwise bx = bx+1.
- frame_done is high in the k=63 cycle when bx == BLOCK_COLS-1 and by == BLOCK_ROWS-1, coincident with block_done.
- restart:
  - In IDLE: bx=by=0 at the next edge. If a handshake occurs in the same cycle, the accepted block is written at (0,0).
  - In WRITE: latched as pending. The current block completes at its original position, then the position becomes (0,0) instead of advancing.
  - frame_done still pulses if the current block was the final block of the frame.
- busy equals (state == WRITE).

Test Plan:
- Release reset, hold table_valid=0 -> table_ready=1; WE, block_done, frame_done and busy all 0; address=0.
- Present one block with pixel p = p (0..63) -> 64 consecutive WE cycles beginning one cycle after the handshake. Addresses are 0..7, 320..327, ..., 2240..2247 with data 0..63. block_done is high on the 64th write only, and table_ready returns one cycle later.
- Hold table_valid=1 continuously for 41 blocks -> handshakes 65 cycles apart. Block 40 writes start at address 2560 (bx=0, by=1). Block 39's last address is 2559.
- Stream 1200 blocks -> the final write is address 76799 with frame_done and block_done both high. Block 1201 starts at address 0.
- Assert rst at the k=20 write cycle -> WE falls immediately and table_ready=1. The next block is written at address 0.
- Pulse restart during block 5's write -> block 5 completes at addresses starting at 40. Block 6 starts at address 0; no frame_done is generated.

Source files
------------

// File: rtl/image_block_writer_if.sv
// Handshake and image RAM write bundle between the IDCT output, the block writer and the frame RAM.
// The slave modport is the writer; the master modport is the IDCT/RAM side that faces it.
interface image_block_writer_if #(
    parameter int TABLE_SIZE  = 64,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 17
);
    logic [TABLE_SIZE*PIXEL_WIDTH-1:0] table_data;
    logic                              table_valid;
    logic                              table_ready;
    logic                              restart;
    logic [ADDR_WIDTH-1:0]             image_RAM_address;
    logic [PIXEL_WIDTH-1:0]            image_RAM_data;
    logic                              image_RAM_WE;
    logic                              block_done;
    logic                              frame_done;
    logic                              busy;

    modport slave (
        input  table_data, table_valid, restart,
        output table_ready, image_RAM_address, image_RAM_data, image_RAM_WE,
               block_done, frame_done, busy
    );

    modport master (
        output table_data, table_valid, restart,
        input  table_ready, image_RAM_address, image_RAM_data, image_RAM_WE,
               block_done, frame_done, busy
    );
endinterface

// File: rtl/image_block_writer.sv
// Writes captured 8x8 pixel blocks into the frame RAM one pixel per clock, in raster block order.
// Addresses are stepped incrementally from a per-block base address, so no multiplier is needed.
module image_block_writer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int PIXEL_WIDTH  = 8,
    parameter int TABLE_SIZE   = 64,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    image_block_writer_if.slave  bus
);
    localparam int BLOCK_COLS = IMAGE_WIDTH / 8;
    localparam int BLOCK_ROWS = IMAGE_HEIGHT / 8;
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMAGE_WIDTH - 7);
    localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ROW_WRAP = ADDR_WIDTH'(7 * IMAGE_WIDTH + 8);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                            state_q, state_d;
    logic [TABLE_SIZE*PIXEL_WIDTH-1:0] buf_q, buf_d;
    logic [5:0]                        k_q, k_d;
    logic [15:0]                       bx_q, bx_d, by_q, by_d;
    logic [ADDR_WIDTH-1:0]             base_q, base_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [PIXEL_WIDTH-1:0]            data_q, data_d;
    logic                              we_q, we_d;
    logic                              ready_q, ready_d;
    logic                              bdone_q, bdone_d;
    logic                              fdone_q, fdone_d;
    logic                              pend_q, pend_d;
    logic [5:0]                        k_nx;
    logic                              last_col, last_row;

    assign last_col = (bx_q == 16'(BLOCK_COLS - 1));
    assign last_row = (by_q == 16'(BLOCK_ROWS - 1));
    assign k_nx     = k_q + 6'd1;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        k_d     = k_q;
        bx_d    = bx_q;
        by_d    = by_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        we_d    = 1'b0;
        bdone_d = 1'b0;
        fdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.restart) begin
                    bx_d   = '0;
                    by_d   = '0;
                    base_d = '0;
                end
                if (bus.table_valid && ready_q) begin
                    state_d = WRITE;
                    buf_d   = bus.table_data;
                    k_d     = '0;
                    ready_d = 1'b0;
                    we_d    = 1'b1;
                    data_d  = bus.table_data[PIXEL_WIDTH-1:0];
                    addr_d  = bus.restart ? '0 : base_q;
                    pend_d  = 1'b0;
                end
            end
            WRITE: begin
                if (bus.restart) pend_d = 1'b1;
                if (k_q == 6'd63) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    pend_d  = 1'b0;
                    // A restart seen at any point during the block overrides the normal advance
                    if (pend_q || bus.restart) begin
                        bx_d   = '0;
                        by_d   = '0;
                        base_d = '0;
                    end else if (last_col) begin
                        bx_d = '0;
                        if (last_row) begin
                            by_d   = '0;
                            base_d = '0;
                        end else begin
                            by_d   = by_q + 16'd1;
                            base_d = base_q + ROW_WRAP;
                        end
                    end else begin
                        bx_d   = bx_q + 16'd1;
                        base_d = base_q + BLK_STEP;
                    end
                end else begin
                    k_d     = k_nx;
                    we_d    = 1'b1;
                    data_d  = buf_q[k_nx*PIXEL_WIDTH +: PIXEL_WIDTH];
                    addr_d  = (k_q[2:0] == 3'd7) ? addr_q + ROW_STEP : addr_q + 1'b1;
                    bdone_d = (k_nx == 6'd63);
                    fdone_d = (k_nx == 6'd63) && last_col && last_row;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            k_q     <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            bdone_q <= 1'b0;
            fdone_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            k_q     <= k_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            bdone_q <= bdone_d;
            fdone_q <= fdone_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.table_ready       = ready_q;
    assign bus.image_RAM_address = addr_q;
    assign bus.image_RAM_data    = data_q;
    assign bus.image_RAM_WE      = we_q;
    assign bus.block_done        = bdone_q;
    assign bus.frame_done        = fdone_q;
    assign bus.busy              = (state_q == WRITE);
endmodule

// File: tb/tb_image_block_writer.sv
// Directed bench for image_block_writer on a 320x240 frame: single block, reset mid-block,
// restart during a write, and a full-frame stream with wrap-around.
module tb_image_block_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   first_addr [0:1300];
    int   last_addr  [0:1300];
    int   first_cyc  [0:1300];
    bit   bd_last    [0:1300];
    bit   fd_last    [0:1300];
    int   fd_total, bd_total, bd_misplaced, blocks_seen;
    bit   timed_out;

    always #5 clk = ~clk;

    image_block_writer_if #(.TABLE_SIZE(64), .PIXEL_WIDTH(8), .ADDR_WIDTH(17)) bus ();

    image_block_writer #(
        .IMAGE_WIDTH(320), .IMAGE_HEIGHT(240), .PIXEL_WIDTH(8), .TABLE_SIZE(64), .ADDR_WIDTH(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Drives n blocks with table_valid held high and records what the RAM port shows; no checking here.
    task automatic stream_blocks(input int n, input bit rs_first, input int rs_blk);
        int wcount, cyc, b, k;
        wcount = 0; cyc = 0; blocks_seen = 0;
        fd_total = 0; bd_total = 0; bd_misplaced = 0; timed_out = 0;
        @(negedge clk);
        bus.table_valid = 1'b1;
        bus.restart     = rs_first;
        while (wcount < n * 64 && !timed_out) begin
            @(negedge clk);
            cyc++;
            if (bus.image_RAM_WE) begin
                b = wcount / 64;
                k = wcount % 64;
                if (k == 0) begin
                    first_addr[b] = int'(bus.image_RAM_address);
                    first_cyc[b]  = cyc;
                    blocks_seen++;
                end
                if (k == 63) begin
                    last_addr[b] = int'(bus.image_RAM_address);
                    bd_last[b]   = bus.block_done;
                    fd_last[b]   = bus.frame_done;
                end
                if (bus.block_done && k != 63) bd_misplaced++;
                wcount++;
            end else if (bus.block_done) begin
                bd_misplaced++;
            end
            if (bus.block_done) bd_total++;
            if (bus.frame_done) fd_total++;
            bus.table_valid = (blocks_seen < n);
            bus.restart     = (rs_blk >= 0) && (wcount == rs_blk * 64 + 10);
            if (cyc > n * 65 + 50) timed_out = 1'b1;
        end
        bus.table_valid = 1'b0;
        bus.restart     = 1'b0;
    endtask

    task automatic test_reset;
        bus.table_valid = 1'b0;
        bus.restart     = 1'b0;
        bus.table_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.table_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.table_ready); end
        checks++; if (bus.image_RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.image_RAM_WE); end
        checks++; if (bus.block_done !== 1'b0) begin errors++; $display("FAIL reset_block_done: got %b expected 0", bus.block_done); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.image_RAM_address !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.image_RAM_address); end
    endtask

    task automatic test_single_block;
        int exp_addr;
        for (int p = 0; p < 64; p++) bus.table_data[p*8 +: 8] = 8'(p);
        bus.table_valid = 1'b1;
        @(negedge clk);
        bus.table_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            exp_addr = (i / 8) * 320 + (i % 8);
            checks++; if (bus.image_RAM_WE !== 1'b1) begin errors++; $display("FAIL single_we[%0d]: got %b expected 1", i, bus.image_RAM_WE); end
            checks++; if (int'(bus.image_RAM_address) !== exp_addr) begin errors++; $display("FAIL single_addr[%0d]: got %0d expected %0d", i, bus.image_RAM_address, exp_addr); end
            checks++; if (int'(bus.image_RAM_data) !== i) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, bus.image_RAM_data, i); end
            checks++; if (bus.block_done !== (i == 63)) begin errors++; $display("FAIL single_block_done[%0d]: got %b expected %b", i, bus.block_done, (i == 63)); end
            checks++; if (bus.table_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low[%0d]: got %b expected 0", i, bus.table_ready); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy[%0d]: got %b expected 1", i, bus.busy); end
        end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL single_frame_done: got %b expected 0", bus.frame_done); end
        @(negedge clk);
        checks++; if (bus.table_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b expected 1", bus.table_ready); end
        checks++; if (bus.image_RAM_WE !== 1'b0) begin errors++; $display("FAIL single_we_after: got %b expected 0", bus.image_RAM_WE); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int wcount, cyc;
        wcount = 0; cyc = 0;
        bus.table_valid = 1'b1;
        while (wcount <= 20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.image_RAM_WE) begin
                bus.table_valid = 1'b0;
                if (wcount == 0) begin
                    checks++; if (bus.image_RAM_address !== 17'd8) begin errors++; $display("FAIL mid_first_addr: got %0d expected 8", bus.image_RAM_address); end
                end
                wcount++;
            end
        end
        checks++; if (wcount != 21) begin errors++; $display("FAIL mid_reach_k20: got %0d writes expected 21", wcount); end
        rst = 1'b1;
        #1;
        checks++; if (bus.image_RAM_WE !== 1'b0) begin errors++; $display("FAIL mid_we_drop: got %b expected 0", bus.image_RAM_WE); end
        checks++; if (bus.table_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.table_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        repeat (2) @(negedge clk);
        checks++; if (bus.image_RAM_WE !== 1'b0) begin errors++; $display("FAIL mid_we_held: got %b expected 0", bus.image_RAM_WE); end
        rst = 1'b0;
        stream_blocks(1, 1'b0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL mid_next_timeout: got timeout expected completion"); end
        checks++; if (first_addr[0] !== 0) begin errors++; $display("FAIL mid_next_first: got %0d expected 0", first_addr[0]); end
        checks++; if (last_addr[0] !== 2247) begin errors++; $display("FAIL mid_next_last: got %0d expected 2247", last_addr[0]); end
    endtask

    task automatic test_restart;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stream_blocks(7, 1'b0, 5);
        checks++; if (timed_out) begin errors++; $display("FAIL rs_timeout: got timeout expected completion"); end
        checks++; if (first_addr[4] !== 32) begin errors++; $display("FAIL rs_blk4_first: got %0d expected 32", first_addr[4]); end
        checks++; if (first_addr[5] !== 40) begin errors++; $display("FAIL rs_blk5_first: got %0d expected 40", first_addr[5]); end
        checks++; if (last_addr[5] !== 2287) begin errors++; $display("FAIL rs_blk5_last: got %0d expected 2287", last_addr[5]); end
        checks++; if (first_addr[6] !== 0) begin errors++; $display("FAIL rs_blk6_first: got %0d expected 0", first_addr[6]); end
        checks++; if (fd_total !== 0) begin errors++; $display("FAIL rs_frame_done: got %0d pulses expected 0", fd_total); end
        checks++; if (bd_total !== 7) begin errors++; $display("FAIL rs_block_done: got %0d pulses expected 7", bd_total); end
    endtask

    task automatic test_back_to_back;
        int bad_pos, bad_gap, bb, exp;
        // Restart asserted with the first handshake also forces this block to (0,0)
        stream_blocks(1201, 1'b1, -1);
        bad_pos = 0; bad_gap = 0;
        for (int b = 0; b < 1201; b++) begin
            bb  = b % 1200;
            exp = (bb / 40) * 2560 + (bb % 40) * 8;
            if (first_addr[b] != exp) bad_pos++;
            if (b > 0 && first_cyc[b] - first_cyc[b-1] != 65) bad_gap++;
        end
        checks++; if (timed_out) begin errors++; $display("FAIL bb_timeout: got timeout expected completion"); end
        checks++; if (first_addr[0] !== 0) begin errors++; $display("FAIL bb_restart_idle_first: got %0d expected 0", first_addr[0]); end
        checks++; if (first_addr[1] !== 8) begin errors++; $display("FAIL bb_blk1_first: got %0d expected 8", first_addr[1]); end
        checks++; if (last_addr[39] !== 2559) begin errors++; $display("FAIL bb_blk39_last: got %0d expected 2559", last_addr[39]); end
        checks++; if (first_addr[40] !== 2560) begin errors++; $display("FAIL bb_blk40_first: got %0d expected 2560", first_addr[40]); end
        checks++; if (first_cyc[40] - first_cyc[39] !== 65) begin errors++; $display("FAIL bb_spacing: got %0d expected 65", first_cyc[40] - first_cyc[39]); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL bb_all_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (bad_pos !== 0) begin errors++; $display("FAIL bb_all_positions: got %0d bad blocks expected 0", bad_pos); end
        checks++; if (last_addr[1199] !== 76799) begin errors++; $display("FAIL bb_frame_last_addr: got %0d expected 76799", last_addr[1199]); end
        checks++; if (fd_last[1199] !== 1'b1) begin errors++; $display("FAIL bb_frame_done_last: got %b expected 1", fd_last[1199]); end
        checks++; if (bd_last[1199] !== 1'b1) begin errors++; $display("FAIL bb_block_done_last: got %b expected 1", bd_last[1199]); end
        checks++; if (first_addr[1200] !== 0) begin errors++; $display("FAIL bb_wrap_first: got %0d expected 0", first_addr[1200]); end
        checks++; if (fd_total !== 1) begin errors++; $display("FAIL bb_frame_done_count: got %0d expected 1", fd_total); end
        checks++; if (bd_total !== 1201) begin errors++; $display("FAIL bb_block_done_count: got %0d expected 1201", bd_total); end
        checks++; if (bd_misplaced !== 0) begin errors++; $display("FAIL bb_block_done_place: got %0d stray expected 0", bd_misplaced); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
